fifo_tx_sync: RTL and testbench

Parametrised synchronous transmit FIFO that buffers frames between the host side and the TX serialiser.
- Generalises the fixed 8x16 TX FIFO to any width and any power-of-two depth.
- Adds a proper reset, per-port handshakes, an occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags.
- Runs on the TX clock domain, single clock.

---
 rtl/fifo_tx_pkg.sv | 19 +
 rtl/fifo_tx_sync_if.sv | 37 +++
 rtl/fifo_tx_mem.sv | 40 ++++
 rtl/fifo_tx_sync.sv | 106 ++++++++++
 tb/tb_fifo_tx_sync.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_tx_pkg.sv
// Shared constants and sizing helpers for the TX FIFO.
// Pointers and the occupancy count carry one bit more than the memory address.
package fifo_tx_pkg;

  localparam int FIFO_TX_DW_DEF     = 8;
  localparam int FIFO_TX_DEPTH_DEF  = 16;
  localparam int FIFO_TX_AFULL_DEF  = 14;
  localparam int FIFO_TX_AEMPTY_DEF = 2;

  function automatic int FIFO_TX_ADDR_W(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // The extra MSB tells a full FIFO apart from an empty one.
  function automatic int FIFO_TX_PTR_W(input int depth);
    return FIFO_TX_ADDR_W(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_tx_sync_if.sv
// Host-side write, serialiser-side read and status signals of the TX FIFO.
// master = user of the FIFO, slave = the FIFO itself.
interface fifo_tx_sync_if
  import fifo_tx_pkg::*;
#(
  parameter int DATA_WIDTH     = FIFO_TX_DW_DEF,
  parameter int MAX_FIFO_FRAME = FIFO_TX_DEPTH_DEF
);
  localparam int CNT_W = FIFO_TX_PTR_W(MAX_FIFO_FRAME);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  fifo_tx_full;
  logic                  fifo_tx_empty;
  logic                  fifo_tx_afull;
  logic                  fifo_tx_aempty;
  logic [CNT_W-1:0]      fifo_tx_count;
  logic                  fifo_tx_ovf;
  logic                  fifo_tx_udf;
  logic                  parity_err;

  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, data_valid, fifo_tx_full, fifo_tx_empty, fifo_tx_afull,
           fifo_tx_aempty, fifo_tx_count, fifo_tx_ovf, fifo_tx_udf, parity_err
  );

  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, data_valid, fifo_tx_full, fifo_tx_empty, fifo_tx_afull,
           fifo_tx_aempty, fifo_tx_count, fifo_tx_ovf, fifo_tx_udf, parity_err
  );

endinterface

// File: rtl/fifo_tx_mem.sv
// Simple dual-port register array: synchronous write, registered read with enable.
// Latency 1 cycle on read; no backpressure, the caller only enables legal accesses.
module fifo_tx_mem
  import fifo_tx_pkg::*;
#(
  parameter int WIDTH = FIFO_TX_DW_DEF,
  parameter int DEPTH = FIFO_TX_DEPTH_DEF,
  parameter int AW    = FIFO_TX_ADDR_W(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_dat_q, rd_dat_d;

  // Storage is deliberately left unreset; only the output register clears.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_dat;
  end

  always_comb begin
    rd_dat_d = rd_dat_q;
    if (rd_en) rd_dat_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_dat_q <= '0;
    else        rd_dat_q <= rd_dat_d;
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/fifo_tx_sync.sv
// Single-clock TX FIFO with count, almost flags and sticky ovf/udf; parity via FIFO_TX_PARITY_EN.
// Read latency 1 cycle, no fall-through; writes when full refused unless a read frees a slot.
module fifo_tx_sync
  import fifo_tx_pkg::*;
#(
  parameter int DATA_WIDTH     = FIFO_TX_DW_DEF,
  parameter int MAX_FIFO_FRAME = FIFO_TX_DEPTH_DEF,
  parameter int AFULL_LVL      = FIFO_TX_AFULL_DEF,
  parameter int AEMPTY_LVL     = FIFO_TX_AEMPTY_DEF
) (
  input  logic          clk_fifo_tx,
  input  logic          rst_fifo_tx_n,
  fifo_tx_sync_if.slave fif
);

  localparam int AW = FIFO_TX_ADDR_W(MAX_FIFO_FRAME);
  localparam int PW = FIFO_TX_PTR_W(MAX_FIFO_FRAME);
`ifdef FIFO_TX_PARITY_EN
  localparam int MW = DATA_WIDTH + 1;
`else
  localparam int MW = DATA_WIDTH;
`endif

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          afull_q, afull_d, aempty_q, aempty_d;
  logic          ovf_q, ovf_d, udf_q, udf_d, valid_q, valid_d;
  logic          wr_ok, rd_ok;
  logic [MW-1:0] wr_word, rd_word;

  always_comb begin
    rd_ok    = fif.rd_en && !empty_q;
    wr_ok    = fif.wr_en && (!full_q || rd_ok);
    wptr_d   = wptr_q + PW'(wr_ok);
    rptr_d   = rptr_q + PW'(rd_ok);
    // Occupancy from the next pointers keeps flags aligned with the count.
    count_d  = wptr_d - rptr_d;
    full_d   = (count_d == PW'(MAX_FIFO_FRAME));
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= PW'(AFULL_LVL));
    aempty_d = (count_d <= PW'(AEMPTY_LVL));
    ovf_d    = ovf_q | (fif.wr_en & ~wr_ok);
    udf_d    = udf_q | (fif.rd_en & ~rd_ok);
    valid_d  = rd_ok;
  end

  always_ff @(posedge clk_fifo_tx or negedge rst_fifo_tx_n) begin
    if (!rst_fifo_tx_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      valid_q  <= valid_d;
    end
  end

`ifdef FIFO_TX_PARITY_EN
  assign wr_word = {^fif.data_in, fif.data_in};
  // Stored word is only meaningful in the cycle it was popped.
  assign fif.parity_err = valid_q & ((^rd_word[DATA_WIDTH-1:0]) ^ rd_word[DATA_WIDTH]);
`else
  assign wr_word = fif.data_in;
  assign fif.parity_err = 1'b0;
`endif

  fifo_tx_mem #(
    .WIDTH (MW),
    .DEPTH (MAX_FIFO_FRAME)
  ) u_mem (
    .clk     (clk_fifo_tx),
    .rst_n   (rst_fifo_tx_n),
    .wr_en   (wr_ok),
    .wr_addr (wptr_q[AW-1:0]),
    .wr_dat  (wr_word),
    .rd_en   (rd_ok),
    .rd_addr (rptr_q[AW-1:0]),
    .rd_dat  (rd_word)
  );

  assign fif.data_out       = rd_word[DATA_WIDTH-1:0];
  assign fif.data_valid     = valid_q;
  assign fif.fifo_tx_full   = full_q;
  assign fif.fifo_tx_empty  = empty_q;
  assign fif.fifo_tx_afull  = afull_q;
  assign fif.fifo_tx_aempty = aempty_q;
  assign fif.fifo_tx_count  = count_q;
  assign fif.fifo_tx_ovf    = ovf_q;
  assign fif.fifo_tx_udf    = udf_q;

endmodule

// File: tb/tb_fifo_tx_sync.sv
// Directed-vector bench for fifo_tx_sync at default parameters (8 bits x 16 entries).
module tb_fifo_tx_sync;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  fifo_tx_sync_if #(.DATA_WIDTH(8), .MAX_FIFO_FRAME(16)) fif ();

  fifo_tx_sync #(
    .DATA_WIDTH     (8),
    .MAX_FIFO_FRAME (16),
    .AFULL_LVL      (14),
    .AEMPTY_LVL     (2)
  ) dut (
    .clk_fifo_tx   (clk),
    .rst_fifo_tx_n (rst_n),
    .fif           (fif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock and land just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    fif.wr_en = 1'b0;
    fif.rd_en = 1'b0;
    fif.data_in = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_empty"},  32'(fif.fifo_tx_empty),  32'd1);
    chk({tag, "_aempty"}, 32'(fif.fifo_tx_aempty), 32'd1);
    chk({tag, "_full"},   32'(fif.fifo_tx_full),   32'd0);
    chk({tag, "_afull"},  32'(fif.fifo_tx_afull),  32'd0);
    chk({tag, "_count"},  32'(fif.fifo_tx_count),  32'd0);
    chk({tag, "_valid"},  32'(fif.data_valid),     32'd0);
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] e;

    fif.wr_en = 1'b0;
    fif.rd_en = 1'b0;
    fif.data_in = '0;

    // Reset and idle
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    chk_idle("rst");
    chk("rst_ovf",  32'(fif.fifo_tx_ovf), 32'd0);
    chk("rst_udf",  32'(fif.fifo_tx_udf), 32'd0);
    chk("rst_dout", 32'(fif.data_out),    32'd0);
    chk("rst_perr", 32'(fif.parity_err),  32'd0);

    // Fill 0x01..0x10, then overflow, then drain in order
    for (int i = 1; i <= 16; i++) begin
      fif.wr_en = 1'b1;
      fif.data_in = 8'(i);
      tick();
      chk("fill_count",  32'(fif.fifo_tx_count),  32'(i));
      chk("fill_afull",  32'(fif.fifo_tx_afull),  32'(i >= 14));
      chk("fill_aempty", 32'(fif.fifo_tx_aempty), 32'(i <= 2));
      chk("fill_full",   32'(fif.fifo_tx_full),   32'(i == 16));
    end
    fif.data_in = 8'hFF;
    tick();
    chk("ovf_flag",  32'(fif.fifo_tx_ovf),   32'd1);
    chk("ovf_count", 32'(fif.fifo_tx_count), 32'd16);
    fif.wr_en = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      fif.rd_en = 1'b1;
      tick();
      chk("drain_dout",  32'(fif.data_out),      32'(i));
      chk("drain_valid", 32'(fif.data_valid),    32'd1);
      chk("drain_count", 32'(fif.fifo_tx_count), 32'(16 - i));
    end
    fif.rd_en = 1'b0;
    tick();
    chk_idle("drained");
    chk("hold_dout", 32'(fif.data_out),    32'h10);
    chk("drain_udf", 32'(fif.fifo_tx_udf), 32'd0);

    // Full with concurrent read+write across pointer wrap
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      fif.wr_en = 1'b1;
      fif.data_in = 8'(8'h20 + i);
      exp_q.push_back(8'(8'h20 + i));
      tick();
    end
    chk("wrap_full0", 32'(fif.fifo_tx_full), 32'd1);
    for (int k = 0; k < 20; k++) begin
      fif.wr_en = 1'b1;
      fif.rd_en = 1'b1;
      fif.data_in = 8'(8'h30 + k);
      exp_q.push_back(8'(8'h30 + k));
      tick();
      e = exp_q.pop_front();
      chk("wrap_dout",  32'(fif.data_out),      32'(e));
      chk("wrap_count", 32'(fif.fifo_tx_count), 32'd16);
      chk("wrap_full",  32'(fif.fifo_tx_full),  32'd1);
    end
    fif.wr_en = 1'b0;
    for (int k = 0; k < 16; k++) begin
      fif.rd_en = 1'b1;
      tick();
      e = exp_q.pop_front();
      chk("wrap_drain", 32'(fif.data_out), 32'(e));
    end
    fif.rd_en = 1'b0;
    tick();
    chk("wrap_ovf",   32'(fif.fifo_tx_ovf),   32'd0);
    chk("wrap_udf",   32'(fif.fifo_tx_udf),   32'd0);
    chk("wrap_empty", 32'(fif.fifo_tx_empty), 32'd1);

    // No fall-through on an empty FIFO
    do_reset();
    fif.wr_en = 1'b1;
    fif.rd_en = 1'b1;
    fif.data_in = 8'hA5;
    tick();
    chk("nft_udf",   32'(fif.fifo_tx_udf),   32'd1);
    chk("nft_count", 32'(fif.fifo_tx_count), 32'd1);
    chk("nft_valid", 32'(fif.data_valid),    32'd0);
    fif.wr_en = 1'b0;
    tick();
    chk("nft_dout",   32'(fif.data_out),      32'hA5);
    chk("nft_valid2", 32'(fif.data_valid),    32'd1);
    chk("nft_count2", 32'(fif.fifo_tx_count), 32'd0);
    fif.rd_en = 1'b0;

    // Asynchronous reset mid-cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      fif.wr_en = 1'b1;
      fif.data_in = 8'(8'h41 + i);
      tick();
    end
    fif.wr_en = 1'b0;
    fif.rd_en = 1'b1;
    tick();
    fif.rd_en = 1'b0;
    chk("pre_dout", 32'(fif.data_out), 32'h41);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("arst");
    chk("arst_dout", 32'(fif.data_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fif.rd_en = 1'b1;
    tick();
    fif.rd_en = 1'b0;
    chk("arst_udf",   32'(fif.fifo_tx_udf), 32'd1);
    chk("arst_valid", 32'(fif.data_valid),  32'd0);

`ifdef FIFO_TX_PARITY_EN
    // Corrupt entry 0 after write; entry 1 stays clean
    do_reset();
    fif.wr_en = 1'b1;
    fif.data_in = 8'h5A;
    tick();
    fif.data_in = 8'h3C;
    tick();
    fif.wr_en = 1'b0;
    dut.u_mem.mem_q[0][0] = ~dut.u_mem.mem_q[0][0];
    fif.rd_en = 1'b1;
    tick();
    chk("par_bad_valid", 32'(fif.data_valid), 32'd1);
    chk("par_bad_err",   32'(fif.parity_err), 32'd1);
    chk("par_bad_dout",  32'(fif.data_out),   32'h5B);
    tick();
    fif.rd_en = 1'b0;
    chk("par_ok_dout", 32'(fif.data_out),   32'h3C);
    chk("par_ok_err",  32'(fif.parity_err), 32'd0);
    tick();
    chk("par_idle_err", 32'(fif.parity_err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
